// File: rtl/time_edit_pkg.sv
// -----------------------------------------------------------------------------
// time_edit_pkg
// Shared types and constants for the set-time edit buffer: key operation codes,
// FSM states, string geometry and the nibble-index-to-bit-offset rule.
// Optional build macro used by the slice: TIME_EDIT_WRAP_EN (cursor wraps
// instead of saturating; consumed in time_edit_cursor).
// -----------------------------------------------------------------------------
package time_edit_pkg;

    localparam int         NIBBLES     = 21;
    localparam int         STR_W       = NIBBLES * 4;
    localparam logic [4:0] CURSOR_HOME = 5'd20;

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_LEFT   = 3'd1,
        OP_RIGHT  = 3'd2,
        OP_WRITE  = 3'd3,
        OP_CLEAR  = 3'd4,
        OP_COMMIT = 3'd5,
        OP_RSV6   = 3'd6,
        OP_RSV7   = 3'd7
    } key_op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EDIT     = 2'd1,
        ST_CLEAR    = 2'd2,
        ST_WAIT_ACK = 2'd3
    } state_e;

    // Nibble i lives at bits [4i+3:4i].
    function automatic logic [6:0] nib_off(input logic [4:0] idx);
        return {idx, 2'b00};
    endfunction

endpackage

// File: rtl/time_edit_cursor.sv
// -----------------------------------------------------------------------------
// time_edit_cursor
// Combinational next-cursor: steps the cursor one place left (towards the most
// significant nibble, index + 1) or right (index - 1).
// Build macro: TIME_EDIT_WRAP_EN -- defined: 20 -> 0 on LEFT, 0 -> 20 on RIGHT;
// undefined: saturate at both ends.
// Ports:
//   count_i  current cursor index 0..20
//   left_i   1 = step left, 0 = step right
//   next_o   cursor index after the step
// -----------------------------------------------------------------------------
module time_edit_cursor
    import time_edit_pkg::*;
(
    input  logic [4:0] count_i,
    input  logic       left_i,
    output logic [4:0] next_o
);

    // Next-cursor arithmetic with end-of-range handling.
    always_comb begin
        next_o = count_i;
        if (left_i) begin
            if (count_i >= CURSOR_HOME) begin
`ifdef TIME_EDIT_WRAP_EN
                next_o = 5'd0;
`else
                next_o = CURSOR_HOME;
`endif
            end else begin
                next_o = count_i + 5'd1;
            end
        end else begin
            if (count_i == 5'd0) begin
`ifdef TIME_EDIT_WRAP_EN
                next_o = CURSOR_HOME;
`else
                next_o = 5'd0;
`endif
            end else begin
                next_o = count_i - 5'd1;
            end
        end
    end

endmodule

// File: rtl/time_edit_buffer.sv
// -----------------------------------------------------------------------------
// time_edit_buffer
// Owns the 21-nibble set-time string and its edit cursor. Key operations arrive
// over key_valid/key_ready; a committed snapshot leaves over
// commit_valid/commit_ready. Editing is live only while mode == 0.
// Build macro: TIME_EDIT_WRAP_EN (cursor wrap instead of saturation).
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   mode                  system mode, 0 = set-time
//   key_valid/key_op/key_digit/key_ready   key operation handshake
//   tmp1                  current string (to the window selector)
//   count                 cursor index 0..20
//   commit_valid/commit_data/commit_ready  snapshot handshake
// -----------------------------------------------------------------------------
module time_edit_buffer
    import time_edit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  mode,
    input  logic        key_valid,
    input  logic [2:0]  key_op,
    input  logic [3:0]  key_digit,
    output logic        key_ready,
    output logic [83:0] tmp1,
    output logic [4:0]  count,
    output logic        commit_valid,
    output logic [83:0] commit_data,
    input  logic        commit_ready
);

    state_e           state_q, state_d;
    logic [STR_W-1:0] tmp1_q, tmp1_d;
    logic [4:0]       count_q, count_d;
    logic [4:0]       clear_idx_q, clear_idx_d;
    logic             commit_valid_q, commit_valid_d;
    logic [STR_W-1:0] commit_data_q, commit_data_d;

    key_op_e          op_s;
    logic             edit_en_s;
    logic             key_xfer_s;
    logic             cursor_left_s;
    logic [4:0]       cursor_next_s;

    assign op_s          = key_op_e'(key_op);
    assign edit_en_s     = (mode == 4'd0);
    assign key_xfer_s    = key_valid & key_ready;
    assign cursor_left_s = (op_s == OP_LEFT);

    // WRITE shares the RIGHT step for its auto-advance.
    time_edit_cursor u_cursor (
        .count_i (count_q),
        .left_i  (cursor_left_s),
        .next_o  (cursor_next_s)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            tmp1_q         <= {STR_W{1'b0}};
            count_q        <= CURSOR_HOME;
            clear_idx_q    <= CURSOR_HOME;
            commit_valid_q <= 1'b0;
            commit_data_q  <= {STR_W{1'b0}};
        end else begin
            state_q        <= state_d;
            tmp1_q         <= tmp1_d;
            count_q        <= count_d;
            clear_idx_q    <= clear_idx_d;
            commit_valid_q <= commit_valid_d;
            commit_data_q  <= commit_data_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (edit_en_s) state_d = ST_EDIT;
                else           state_d = ST_IDLE;
            end
            ST_EDIT: begin
                if (!edit_en_s)                            state_d = ST_IDLE;
                else if (key_xfer_s && op_s == OP_CLEAR)   state_d = ST_CLEAR;
                else if (key_xfer_s && op_s == OP_COMMIT)  state_d = ST_WAIT_ACK;
                else                                       state_d = ST_EDIT;
            end
            ST_CLEAR: begin
                if (!edit_en_s)                state_d = ST_IDLE;
                else if (clear_idx_q == 5'd0)  state_d = ST_EDIT;
                else                           state_d = ST_CLEAR;
            end
            ST_WAIT_ACK: begin
                // The snapshot handshake is never abandoned on a mode change.
                if (commit_ready) state_d = edit_en_s ? ST_EDIT : ST_IDLE;
                else              state_d = ST_WAIT_ACK;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode: key_ready depends on state only.
    always_comb begin
        key_ready = 1'b0;
        case (state_q)
            ST_EDIT: key_ready = 1'b1;
            default: key_ready = 1'b0;
        endcase
    end

    // Datapath next values: string, cursor, clear index, snapshot.
    always_comb begin
        tmp1_d         = tmp1_q;
        count_d        = count_q;
        clear_idx_d    = clear_idx_q;
        commit_valid_d = commit_valid_q;
        commit_data_d  = commit_data_q;
        case (state_q)
            ST_IDLE: begin
                count_d = CURSOR_HOME;
            end
            ST_EDIT: begin
                // A key accepted on the edge where mode leaves 0 is dropped.
                if (!edit_en_s) begin
                    count_d = CURSOR_HOME;
                end else if (key_xfer_s) begin
                    case (op_s)
                        OP_LEFT, OP_RIGHT: count_d = cursor_next_s;
                        OP_WRITE: begin
                            tmp1_d[nib_off(count_q) +: 4] = key_digit;
                            count_d                       = cursor_next_s;
                        end
                        OP_CLEAR:  clear_idx_d = CURSOR_HOME;
                        OP_COMMIT: begin
                            commit_data_d  = tmp1_q;
                            commit_valid_d = 1'b1;
                        end
                        default: count_d = count_q;
                    endcase
                end else begin
                    count_d = count_q;
                end
            end
            ST_CLEAR: begin
                // The nibble under clear_idx is zeroed even on the exit edge.
                tmp1_d[nib_off(clear_idx_q) +: 4] = 4'h0;
                if (!edit_en_s || clear_idx_q == 5'd0) begin
                    count_d = CURSOR_HOME;
                end else begin
                    clear_idx_d = clear_idx_q - 5'd1;
                end
            end
            ST_WAIT_ACK: begin
                if (commit_ready) begin
                    commit_valid_d = 1'b0;
                    if (!edit_en_s) count_d = CURSOR_HOME;
                    else            count_d = count_q;
                end else begin
                    commit_valid_d = 1'b1;
                end
            end
            default: count_d = CURSOR_HOME;
        endcase
    end

    assign tmp1         = tmp1_q;
    assign count        = count_q;
    assign commit_valid = commit_valid_q;
    assign commit_data  = commit_data_q;

endmodule

// File: doc/time_edit_buffer.md
# time_edit_buffer

Write-side companion of the set-time display window: owns the 21-nibble time string and the edit cursor, which the window selector reads to render an 8-nibble viewport. Accepts key operations over a valid/ready handshake, moves the cursor, writes digits, clears the string nibble by nibble, and hands a committed snapshot downstream over a second valid/ready handshake. Editing is live only in mode 0, the set-time mode.

## Interface
- NIBBLES, 21: string length in nibbles; nibble i occupies bits [4i+3:4i].
- CURSOR_HOME, 20: cursor value after reset, mode exit and clear; leftmost, most significant nibble.
- clk  in  1: clock.
- reset  in  1: synchronous, active-high.
- mode  in  4: system mode; editing is enabled only when mode == 0.
- key_valid  in  1: key operation present.
- key_op  in  3: 0 NOP, 1 LEFT, 2 RIGHT, 3 WRITE, 4 CLEAR, 5 COMMIT; 6 and 7 are reserved.
- key_digit  in  4: nibble for WRITE; any value 0x0–0xF.
- key_ready  out  1: key operation accepted this cycle.
- tmp1  out  84: current string; feeds the window selector.
- count  out  5: cursor index, 0..20.
- commit_valid  out  1: snapshot available.
- commit_data  out  84: snapshot taken at COMMIT acceptance.
- commit_ready  in  1: downstream takes the snapshot.

## Operation
- States:
  - IDLE: mode != 0.
  - EDIT
  - CLEAR
  - WAIT_ACK
- IDLE:
  - key_ready = 0.
  - count is forced to CURSOR_HOME.
  - tmp1 is held.
  - Goes to EDIT on the edge where mode == 0.
- EDIT:
  - key_ready = 1.
  - A transfer is key_valid && key_ready.
- Operations on transfer:
  - LEFT: count + 1; at 20, wrap or saturate (see Configuration).
  - RIGHT: count − 1; at 0, wrap or saturate.
  - WRITE: nibble[count] <= key_digit, then cursor steps as RIGHT (auto-advance).
  - CLEAR: go to CLEAR with clear_idx = 20.
  - COMMIT: commit_data <= tmp1, commit_valid <= 1, go to WAIT_ACK.
  - NOP and reserved codes: consumed, no effect.
- CLEAR:
  - Writes 0 to nibble[clear_idx], one nibble per cycle, with clear_idx counting down 20..0.
  - After nibble 0: count = CURSOR_HOME, go to EDIT.
  - key_ready = 0 throughout.
- WAIT_ACK:
  - commit_valid stays high and commit_data stays stable until commit_ready.
  - On the acceptance edge: commit_valid = 0; go to EDIT if mode == 0, otherwise IDLE.
- Mode leaves 0:
  - During EDIT or CLEAR: go to IDLE on the next edge. A partial clear stays partial; count = 20.
  - During WAIT_ACK: the handshake is never dropped; go to IDLE only after acceptance.
- Cursor arithmetic is 5-bit unsigned. Values 21–31 are never produced.

## Timing
- Reset values: state = IDLE, tmp1 = 0, count = 20, key_ready = 0, commit_valid = 0, commit_data = 0.
- All outputs are registered except key_ready, which is decoded from state only.
- Latency:
  - Key effect visible on tmp1/count the cycle after the transfer edge.
  - CLEAR occupies 21 cycles, then EDIT; key_ready returns high on cycle 22.
  - commit_valid rises 1 cycle after COMMIT.
- commit_ready high while commit_valid is low is ignored.
- Reset mid-CLEAR or mid-WAIT_ACK restores all reset values immediately; a pending commit is lost.

## Configuration
- TIME_EDIT_WRAP_EN defined: LEFT at 20 goes to 0; RIGHT and WRITE auto-advance at 0 go to 20.
- TIME_EDIT_WRAP_EN undefined: cursor saturates at 20 and at 0. A WRITE at 0 writes nibble 0 and keeps count = 0.

## Structure
- Package time_edit_pkg holds:
  - key_op codes as a typedef enum.
  - FSM state enum.
  - NIBBLES and CURSOR_HOME constants.
  - The nibble-index-to-bit-offset rule.
- Sub-module time_edit_cursor: combinational next-cursor from current count and a step direction. It contains the wrap/saturate choice under TIME_EDIT_WRAP_EN.

## Test plan
- Reset, then mode = 0 -> tmp1 = 0, count = 20, key_ready = 1 from the second cycle.
- WRITE digits 1,2,3,4 from count 20 -> tmp1[83:68] = 16'h1234, count = 16.
- RIGHT from count 0 -> count = 20 with TIME_EDIT_WRAP_EN, 0 without; LEFT from 20 -> 0 with, 20 without.
- tmp1 all 0xF, CLEAR -> nibble 20 cleared on the first cycle, all zero after 21 cycles, key_ready low throughout, count = 20.
- COMMIT with commit_ready held low 5 cycles -> commit_valid high and commit_data stable for 5 cycles; mode = 3 raised meanwhile -> IDLE only after commit_ready.
- mode = 2 on cycle 10 of CLEAR -> nibbles 20..11 zero, nibbles 10..0 unchanged, count = 20, key_ready = 0.
